src_window_stats: RTL and testbench
===================================

# src_window_stats

Downstream consumer of the `src` mux/adder stage. Accepts one result word plus its overflow flag per valid cycle and groups consecutive samples into fixed windows of 2^LOG2_WIN. At the end of each window it publishes the truncated average, the peak value and a saturating overflow count. These feed debug readout and status logic.

## Interface
- NB_IN, 6, width of incoming result word; matches `src` NB_o_sum2.
- LOG2_WIN, 3, log2 of window length in samples; window length is 8 by default.
- NB_CNT, 4, width of the overflow counter.

- clk  in  1  system clock; rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_valid  in  1  sample strobe; `i_data` and `i_overflow` are sampled only when this is 1.
- i_data  in  NB_IN  unsigned result word from `src` `o_data`.
- i_overflow  in  1  overflow flag accompanying `i_data`, from `src` `o_overflow`.
- i_clear  in  1  synchronous discard of the partial window.
- o_valid  out  1  one-cycle pulse when new window results are presented.
- o_avg  out  NB_IN  window sum >> LOG2_WIN, truncated.
- o_peak  out  NB_IN  maximum `i_data` in the window.
- o_ovf_cnt  out  NB_CNT  number of samples with `i_overflow`=1, saturating.
- o_busy  out  1  1 while a partial window is held, i.e. the block is in ACCUM.

## Operation
- Internal registers:
  - `acc`: NB_IN+LOG2_WIN bits; cannot overflow (8×63=504 fits in 9 bits).
  - `peak`: NB_IN bits.
  - `ovf`: NB_CNT bits.
  - `cnt`: LOG2_WIN bits.
- FSM has two states:
  - IDLE: no samples held.
  - ACCUM: 1 to 2^LOG2_WIN−1 samples held.
- IDLE + accepted sample:
  - `acc`=`i_data`, `peak`=`i_data`, `ovf`=`i_overflow`, `cnt`=1.
  - Go to ACCUM.
- ACCUM + accepted sample:
  - `acc` += `i_data`; `peak` = max(`peak`, `i_data`).
  - `ovf` += `i_overflow`, saturating at 2^NB_CNT−1.
  - `cnt` += 1.
- Window-complete sample: the accepted sample taken when `cnt` = 2^LOG2_WIN−1.
  - Final values include that sample.
  - Final values are loaded into `o_avg`/`o_peak`/`o_ovf_cnt`; `o_valid`=1.
  - FSM returns to IDLE and the internal registers clear.
  - The next sample, even on the immediately following cycle, starts a fresh window. No dead cycle between windows.
- Overflow samples are included in sum and peak using the `i_data` value as given (wrapped).
- `i_valid`=0 cycles are ignored. The window counts samples, not cycles.
- `i_clear`=1:
  - Returns the FSM to IDLE and clears the internal registers.
  - The published outputs hold their last values; `o_valid`=0.
- `i_clear` and `i_valid` in the same cycle: clear wins and the sample is dropped.
- `i_clear` on the window-complete sample: clear wins; no results are published.
- LOG2_WIN=0: every accepted sample is a complete window. The FSM never enters ACCUM.

## Timing
- All outputs are registered.
- Reset values: `o_valid`=0, `o_avg`=0, `o_peak`=0, `o_ovf_cnt`=0, `o_busy`=0. FSM resets to IDLE with all internal registers 0.
- Latency:
  - `o_valid` and the new result values appear on the edge that captures the window-complete sample.
  - They are visible in the cycle after that sample was presented.
- `o_valid` is exactly one cycle wide. Result outputs hold until the next window completes.
- `o_busy` rises on the edge that accepts the first sample of a window. It falls on the completing edge or the clear edge.
- Reset asserted mid-window: all state and outputs go to their reset values immediately, without waiting for a clock. The first accepted sample after release starts a new window.
- No backpressure: the block accepts a sample in every cycle.

## Structure
- Package `src_pkg` holds:
  - FSM state encoding localparams (ST_IDLE=1'b0, ST_ACCUM=1'b1).
  - Shared width defaults (NB_o_sum2=6), used here as the NB_IN default and by `src`.
- Sub-module `sat_counter` (parameter NB, inputs inc and clr, saturating output). It is instantiated for `ovf`.
- Everything else is a single always block for the FSM and datapath, plus an output register block.

## Test plan
- Reset, then 8 valid samples of 5, all with `i_overflow`=0 → one `o_valid` pulse; `o_avg`=5, `o_peak`=5, `o_ovf_cnt`=0, `o_busy`=0 afterwards.
- Samples 0..7 with `i_valid` toggling 1/0 each cycle → `o_valid` only after the 8th accepted sample; `o_avg`=3 (28>>3), `o_peak`=7.
- 8 samples of 63, all with `i_overflow`=1; NB_CNT=4 → `o_avg`=63, `o_peak`=63, `o_ovf_cnt`=8. Rerun with NB_CNT=2 → `o_ovf_cnt`=3 (saturated).
- 3 samples of 40, then `i_clear` asserted together with a sample of 50, then 8 samples of 10 → `o_avg`=10, `o_peak`=10. No `o_valid` before the 8th sample of 10; the prior outputs are held during the clear.
- Two back-to-back windows (16 consecutive samples: 8×2, then 8×4) → `o_valid` pulses exactly 8 cycles apart, with `o_avg`=2 then 4.
- 5 samples accepted, then `i_rst_n` pulled low between clock edges → all outputs go to 0 immediately. After release, 8 samples of 9 → `o_avg`=9.

Source files
------------

// File: rtl/src_pkg.sv
// Shared definitions for the src result path and its downstream consumers.
// Holds the window-statistics FSM encoding and the common result width.
package src_pkg;

    localparam int NB_o_sum2 = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/src_window_stats_sat_counter.sv
// Saturating up-counter with synchronous clear; exposes the next count so the
// owner can publish the value that includes the current increment.
module sat_counter #(
    parameter int NB = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [NB-1:0] o_count_next
);

    localparam logic [NB-1:0] COUNT_MAX = '1;

    logic [NB-1:0] count_q;
    logic [NB-1:0] count_d;

    always_comb begin
        o_count_next = count_q;
        if (inc && (count_q != COUNT_MAX)) begin
            o_count_next = count_q + 1'b1;
        end
        count_d = clr ? '0 : o_count_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/src_window_stats.sv
// Groups accepted src results into windows of 2^LOG2_WIN samples and publishes
// truncated average, peak and saturating overflow count at each window end.
module src_window_stats
    import src_pkg::*;
#(
    parameter int NB_IN    = NB_o_sum2,
    parameter int LOG2_WIN = 3,
    parameter int NB_CNT   = 4
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [NB_IN-1:0]  i_data,
    input  logic              i_overflow,
    input  logic              i_clear,
    output logic              o_valid,
    output logic [NB_IN-1:0]  o_avg,
    output logic [NB_IN-1:0]  o_peak,
    output logic [NB_CNT-1:0] o_ovf_cnt,
    output logic              o_busy
);

    localparam int NB_ACC = NB_IN + LOG2_WIN;
    // A zero-width sample counter is not legal, so LOG2_WIN=0 keeps one bit pinned at 0.
    localparam int NB_SMP = (LOG2_WIN > 0) ? LOG2_WIN : 1;
    localparam logic [NB_SMP-1:0] LAST_CNT = NB_SMP'((1 << LOG2_WIN) - 1);

    state_e              state_q, state_d;
    logic [NB_ACC-1:0]   acc_q, acc_d;
    logic [NB_IN-1:0]    peak_q, peak_d;
    logic [NB_SMP-1:0]   cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [NB_IN-1:0]    avg_out_q, avg_out_d;
    logic [NB_IN-1:0]    peak_out_q, peak_out_d;
    logic [NB_CNT-1:0]   ovf_out_q, ovf_out_d;

    logic                accept;
    logic                win_done;
    logic [NB_ACC-1:0]   acc_sum;
    logic [NB_IN-1:0]    peak_max;
    logic                ovf_clr;
    logic                ovf_inc;
    logic [NB_CNT-1:0]   ovf_next;

    sat_counter #(
        .NB (NB_CNT)
    ) u_ovf_cnt (
        .clk          (clk),
        .rst_n        (i_rst_n),
        .clr          (ovf_clr),
        .inc          (ovf_inc),
        .o_count_next (ovf_next)
    );

    // Internal registers are zero whenever IDLE, so the first sample of a
    // window can share the accumulate path instead of a separate load path.
    always_comb begin
        accept   = i_valid && !i_clear;
        win_done = accept && (cnt_q == LAST_CNT);
        acc_sum  = acc_q + NB_ACC'(i_data);
        peak_max = (i_data > peak_q) ? i_data : peak_q;
        ovf_inc  = accept && i_overflow;

        state_d    = state_q;
        acc_d      = acc_q;
        peak_d     = peak_q;
        cnt_d      = cnt_q;
        ovf_clr    = 1'b0;
        valid_d    = 1'b0;
        avg_out_d  = avg_out_q;
        peak_out_d = peak_out_q;
        ovf_out_d  = ovf_out_q;

        if (i_clear || win_done) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            peak_d  = '0;
            cnt_d   = '0;
            ovf_clr = 1'b1;
        end else if (accept) begin
            state_d = ST_ACCUM;
            acc_d   = acc_sum;
            peak_d  = peak_max;
            cnt_d   = cnt_q + 1'b1;
        end

        if (win_done) begin
            valid_d    = 1'b1;
            avg_out_d  = NB_IN'(acc_sum >> LOG2_WIN);
            peak_out_d = peak_max;
            ovf_out_d  = ovf_next;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            peak_q     <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            avg_out_q  <= '0;
            peak_out_q <= '0;
            ovf_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            peak_q     <= peak_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            avg_out_q  <= avg_out_d;
            peak_out_q <= peak_out_d;
            ovf_out_q  <= ovf_out_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_avg     = avg_out_q;
    assign o_peak    = peak_out_q;
    assign o_ovf_cnt = ovf_out_q;
    assign o_busy    = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_src_window_stats.sv
// Self-checking bench for src_window_stats: directed scenarios plus random
// traffic against a queue-based window model; a second instance uses NB_CNT=2.
module tb_src_window_stats;

    localparam int WIN = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [5:0] data;
    logic       ovf;
    logic       clear;

    logic       a_valid, b_valid;
    logic [5:0] a_avg, a_peak, b_avg, b_peak;
    logic [3:0] a_ovf;
    logic [1:0] b_ovf;
    logic       a_busy, b_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    src_window_stats #(.NB_IN(6), .LOG2_WIN(3), .NB_CNT(4)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
        .i_overflow(ovf), .i_clear(clear), .o_valid(a_valid), .o_avg(a_avg),
        .o_peak(a_peak), .o_ovf_cnt(a_ovf), .o_busy(a_busy)
    );

    src_window_stats #(.NB_IN(6), .LOG2_WIN(3), .NB_CNT(2)) dut2 (
        .clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
        .i_overflow(ovf), .i_clear(clear), .o_valid(b_valid), .o_avg(b_avg),
        .o_peak(b_peak), .o_ovf_cnt(b_ovf), .o_busy(b_busy)
    );

    // Reference model: the window is literally the list of accepted samples.
    int   win_data[$];
    int   win_ovf;
    logic m_valid;
    int   m_avg, m_peak, m_ovf4, m_ovf2;
    logic m_busy;

    task automatic model_reset();
        win_data.delete();
        win_ovf = 0;
        m_valid = 1'b0;
        m_avg = 0; m_peak = 0; m_ovf4 = 0; m_ovf2 = 0;
        m_busy = 1'b0;
    endtask

    task automatic model_step(input logic v, input int d, input logic o, input logic c);
        m_valid = 1'b0;
        if (c) begin
            win_data.delete();
            win_ovf = 0;
        end else if (v) begin
            win_data.push_back(d);
            win_ovf += int'(o);
            if (win_data.size() == WIN) begin
                int s;
                int mx;
                s = 0;
                mx = 0;
                foreach (win_data[k]) begin
                    s += win_data[k];
                    if (win_data[k] > mx) mx = win_data[k];
                end
                m_avg   = s / WIN;
                m_peak  = mx;
                m_ovf4  = (win_ovf > 15) ? 15 : win_ovf;
                m_ovf2  = (win_ovf > 3) ? 3 : win_ovf;
                m_valid = 1'b1;
                win_data.delete();
                win_ovf = 0;
            end
        end
        m_busy = (win_data.size() != 0);
    endtask

    task automatic step(input logic v, input int d, input logic o, input logic c);
        @(negedge clk);
        valid = v;
        data  = 6'(d);
        ovf   = o;
        clear = c;
        @(posedge clk);
        #1;
        model_step(v, d, o, c);
        if (a_valid === 1'b1)
            $display("cycle %0d window: avg=%0d peak=%0d ovf=%0d ovf2=%0d", cycle, a_avg, a_peak, a_ovf, b_ovf);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; data = '0; ovf = 1'b0; clear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_valid, a_avg, a_peak, a_ovf, a_busy} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_a: got v=%b avg=%0d peak=%0d ovf=%0d busy=%b, need all 0", a_valid, a_avg, a_peak, a_ovf, a_busy);
        end
        n_checks++;
        if ({b_valid, b_avg, b_peak, b_ovf, b_busy} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_b: got v=%b avg=%0d peak=%0d ovf=%0d busy=%b, need all 0", b_valid, b_avg, b_peak, b_ovf, b_busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 5, 1'b0, 1'b0);
            n_checks++;
            if (a_valid !== (i == WIN - 1)) begin
                n_fail++;
                $display("FAIL basic_valid[%0d]: got %b need %b", i, a_valid, (i == WIN - 1));
            end
        end
        n_checks++;
        if (a_avg !== 6'd5 || a_peak !== 6'd5 || a_ovf !== 4'd0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got avg=%0d peak=%0d ovf=%0d busy=%b need 5 5 0 0", a_avg, a_peak, a_ovf, a_busy);
        end
        step(1'b0, 0, 1'b0, 1'b0);
        n_checks++;
        if (a_valid !== 1'b0 || a_avg !== 6'd5) begin
            n_fail++;
            $display("FAIL basic_pulse: got valid=%b avg=%0d need 0 5", a_valid, a_avg);
        end
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 2 * WIN; i++) begin
            step((i % 2) == 0, i / 2, 1'b0, 1'b0);
            n_checks++;
            if (a_valid !== (i == 2 * WIN - 2)) begin
                n_fail++;
                $display("FAIL gaps_valid[%0d]: got %b need %b", i, a_valid, (i == 2 * WIN - 2));
            end
        end
        n_checks++;
        if (a_avg !== 6'd3 || a_peak !== 6'd7) begin
            n_fail++;
            $display("FAIL gaps_result: got avg=%0d peak=%0d need 3 7", a_avg, a_peak);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < WIN; i++) step(1'b1, 63, 1'b1, 1'b0);
        n_checks++;
        if (a_valid !== 1'b1 || a_avg !== 6'd63 || a_peak !== 6'd63 || a_ovf !== 4'd8) begin
            n_fail++;
            $display("FAIL ovf_nb4: got v=%b avg=%0d peak=%0d ovf=%0d need 1 63 63 8", a_valid, a_avg, a_peak, a_ovf);
        end
        n_checks++;
        if (b_valid !== 1'b1 || b_ovf !== 2'd3 || b_avg !== 6'd63) begin
            n_fail++;
            $display("FAIL ovf_nb2: got v=%b ovf=%0d avg=%0d need 1 3 63", b_valid, b_ovf, b_avg);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) step(1'b1, 40, 1'b0, 1'b0);
        n_checks++;
        if (a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_busy_before: got %b need 1", a_busy);
        end
        step(1'b1, 50, 1'b0, 1'b1);
        n_checks++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0 || int'(a_avg) !== m_avg || int'(a_peak) !== m_peak) begin
            n_fail++;
            $display("FAIL clear_hold: got v=%b busy=%b avg=%0d peak=%0d need 0 0 %0d %0d",
                     a_valid, a_busy, a_avg, a_peak, m_avg, m_peak);
        end
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 10, 1'b0, 1'b0);
            n_checks++;
            if (a_valid !== (i == WIN - 1)) begin
                n_fail++;
                $display("FAIL clear_valid[%0d]: got %b need %b", i, a_valid, (i == WIN - 1));
            end
        end
        n_checks++;
        if (a_avg !== 6'd10 || a_peak !== 6'd10 || a_ovf !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_result: got avg=%0d peak=%0d ovf=%0d need 10 10 0", a_avg, a_peak, a_ovf);
        end
    endtask

    task automatic test_back_to_back();
        int pulse_cyc[$];
        int pulse_avg[$];
        for (int i = 0; i < 2 * WIN; i++) begin
            step(1'b1, (i < WIN) ? 2 : 4, 1'b0, 1'b0);
            if (a_valid === 1'b1) begin
                pulse_cyc.push_back(cycle);
                pulse_avg.push_back(int'(a_avg));
            end
        end
        n_checks++;
        if (pulse_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d pulses need 2", pulse_cyc.size());
        end else begin
            n_checks++;
            if (pulse_cyc[1] - pulse_cyc[0] != WIN) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d cycles need %0d", pulse_cyc[1] - pulse_cyc[0], WIN);
            end
            n_checks++;
            if (pulse_avg[0] != 2 || pulse_avg[1] != 4) begin
                n_fail++;
                $display("FAIL b2b_avg: got %0d,%0d need 2,4", pulse_avg[0], pulse_avg[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1'b1, 7, 1'b1, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_valid, a_avg, a_peak, a_ovf, a_busy} !== 18'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got v=%b avg=%0d peak=%0d ovf=%0d busy=%b need all 0",
                     a_valid, a_avg, a_peak, a_ovf, a_busy);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            step(1'b1, 9, 1'b0, 1'b0);
            n_checks++;
            if (a_valid !== (i == WIN - 1)) begin
                n_fail++;
                $display("FAIL rst_mid_valid[%0d]: got %b need %b", i, a_valid, (i == WIN - 1));
            end
        end
        n_checks++;
        if (a_avg !== 6'd9 || a_peak !== 6'd9 || a_ovf !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_mid_result: got avg=%0d peak=%0d ovf=%0d need 9 9 0", a_avg, a_peak, a_ovf);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
            n_checks++;
            if (a_valid !== m_valid || a_busy !== m_busy || int'(a_avg) !== m_avg ||
                int'(a_peak) !== m_peak || int'(a_ovf) !== m_ovf4 || int'(b_ovf) !== m_ovf2) begin
                n_fail++;
                $display("FAIL random[%0d]: got v=%b busy=%b avg=%0d peak=%0d ovf=%0d ovf2=%0d need %b %b %0d %0d %0d %0d",
                         i, a_valid, a_busy, a_avg, a_peak, a_ovf, b_ovf,
                         m_valid, m_busy, m_avg, m_peak, m_ovf4, m_ovf2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
